// File: rtl/juego_pkg.sv
// Shared board types, direction codes and move-engine state encoding for the 2048 game.
package juego_pkg;
   localparam int ANCHO_CELDA = 12;
   localparam int N_TABLERO   = 4;
   localparam int IDX_W       = $clog2(N_TABLERO);
   localparam int PUNTOS_W    = 16;

   typedef logic [ANCHO_CELDA-1:0]                       celda_t;
   typedef celda_t [0:N_TABLERO-1]                       columna_t;
   typedef celda_t [0:N_TABLERO-1][0:N_TABLERO-1]        matriz_t;
   typedef logic [PUNTOS_W-1:0]                          puntos_t;

   localparam logic [3:0] ESTADO_ARRIBA = 4'b0001;
   localparam logic [3:0] ESTADO_ABAJO  = 4'b0010;

   // Winning tile; never merged again here.
   localparam celda_t CELDA_MAX = 12'd2048;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLUMNA = 2'd1,
      FIN     = 2'd2
   } estado_mov_t;
endpackage

// File: rtl/mover_abajo_seq_if.sv
// Handshake and board bus between the game FSM (master) and the move-down engine (slave).
interface mover_abajo_seq_if;
   import juego_pkg::*;

   logic       start;
   logic [3:0] estado;
   matriz_t    matriz_in;
   matriz_t    matriz_out;
   logic       busy;
   logic       done;
   logic       movio;
   puntos_t    puntos;

   modport master (
      output start, estado, matriz_in,
      input  matriz_out, busy, done, movio, puntos
   );

   modport slave (
      input  start, estado, matriz_in,
      output matriz_out, busy, done, movio, puntos
   );
endinterface

// File: rtl/mover_abajo_seq_compactar_columna.sv
// Slides one column toward the bottom row and merges equal neighbours once per tile.
module compactar_columna
   import juego_pkg::*;
(
   input  columna_t col_in,
   output columna_t col_out,
   output puntos_t  puntos
);

   celda_t           pend;
   celda_t           v;
   logic [IDX_W-1:0] wr;

   // Walk bottom-up; pend holds the last unmerged tile waiting for a possible partner.
   always_comb begin
      col_out = '0;
      puntos  = '0;
      pend    = '0;
      v       = '0;
      wr      = IDX_W'(N_TABLERO-1);
      for (int i = 0; i < N_TABLERO; i++) begin
         v = col_in[IDX_W'(N_TABLERO-1-i)];
         if (v != '0) begin
            if (pend == v && v != CELDA_MAX) begin
               col_out[wr] = {v[ANCHO_CELDA-2:0], 1'b0};
               puntos      = puntos + puntos_t'({v[ANCHO_CELDA-2:0], 1'b0});
               wr          = wr - IDX_W'(1);
               pend        = '0;
            end else begin
               if (pend != '0) begin
                  col_out[wr] = pend;
                  wr          = wr - IDX_W'(1);
               end
               pend = v;
            end
         end
      end
      if (pend != '0) begin
         col_out[wr] = pend;
      end
   end

endmodule

// File: rtl/mover_abajo_seq.sv
// 2048 "move down" engine: one column per clock from a board snapshot, registered result.
//   state   | meaning
//   IDLE    | waiting for start with estado == ESTADO_ABAJO
//   COLUMNA | processing column col_q of the snapshot
//   FIN     | publish result, pulse done, drop busy
module mover_abajo_seq
   import juego_pkg::*;
(
   input logic              clk,
   input logic              rst,
   mover_abajo_seq_if.slave bus
);

   estado_mov_t      fsm_q,    fsm_d;
   logic [IDX_W-1:0] col_q,    col_d;
   matriz_t          snap_q,   snap_d;
   matriz_t          work_q,   work_d;
   puntos_t          acc_q,    acc_d;
   matriz_t          out_q,    out_d;
   logic             busy_q,   busy_d;
   logic             done_q,   done_d;
   logic             movio_q,  movio_d;
   puntos_t          puntos_q, puntos_d;

   columna_t col_sel;
   columna_t col_res;
   puntos_t  col_pts;

   always_comb begin
      col_sel = '0;
      for (int r = 0; r < N_TABLERO; r++) begin
         col_sel[IDX_W'(r)] = snap_q[IDX_W'(r)][col_q];
      end
   end

   compactar_columna u_compactar (
      .col_in  (col_sel),
      .col_out (col_res),
      .puntos  (col_pts)
   );

   always_comb begin
      fsm_d    = fsm_q;
      col_d    = col_q;
      snap_d   = snap_q;
      work_d   = work_q;
      acc_d    = acc_q;
      out_d    = out_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      movio_d  = movio_q;
      puntos_d = puntos_q;
      case (fsm_q)
         IDLE: begin
            if (bus.start && bus.estado == ESTADO_ABAJO) begin
               snap_d = bus.matriz_in;
               work_d = bus.matriz_in;
               acc_d  = '0;
               col_d  = '0;
               busy_d = 1'b1;
               fsm_d  = COLUMNA;
            end
         end
         COLUMNA: begin
            for (int r = 0; r < N_TABLERO; r++) begin
               work_d[IDX_W'(r)][col_q] = col_res[IDX_W'(r)];
            end
            acc_d = acc_q + col_pts;
            col_d = col_q + IDX_W'(1);
            if (col_q == IDX_W'(N_TABLERO-1)) begin
               fsm_d = FIN;
            end
         end
         FIN: begin
            out_d    = work_q;
            puntos_d = acc_q;
            movio_d  = (work_q != snap_q);
            done_d   = 1'b1;
            busy_d   = 1'b0;
            fsm_d    = IDLE;
         end
         default: fsm_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fsm_q    <= IDLE;
         col_q    <= '0;
         snap_q   <= '0;
         work_q   <= '0;
         acc_q    <= '0;
         out_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         movio_q  <= 1'b0;
         puntos_q <= '0;
      end else begin
         fsm_q    <= fsm_d;
         col_q    <= col_d;
         snap_q   <= snap_d;
         work_q   <= work_d;
         acc_q    <= acc_d;
         out_q    <= out_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         movio_q  <= movio_d;
         puntos_q <= puntos_d;
      end
   end

   assign bus.matriz_out = out_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.movio      = movio_q;
   assign bus.puntos     = puntos_q;

endmodule

// File: tb/tb_mover_abajo_seq.sv
// Directed and randomized checks of mover_abajo_seq against a list-based reference model.
module tb_mover_abajo_seq;
   import juego_pkg::*;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;

   mover_abajo_seq_if bus ();

   mover_abajo_seq dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_m(input string tag, input matriz_t obs, input matriz_t exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: gather non-zero tiles bottom-up, pair them greedily, restack from the bottom.
   function automatic void modelo(input matriz_t b, output matriz_t r, output int pts);
      int lst[$];
      int sal[$];
      r   = '0;
      pts = 0;
      for (int c = 0; c < N_TABLERO; c++) begin
         lst.delete();
         sal.delete();
         for (int f = N_TABLERO-1; f >= 0; f--)
            if (b[f][c] != 0) lst.push_back(int'(b[f][c]));
         for (int a = 0; a < lst.size(); a++) begin
            if (a + 1 < lst.size() && lst[a] == lst[a+1] && lst[a] != 2048) begin
               sal.push_back(2 * lst[a]);
               pts += 2 * lst[a];
               a++;
            end else begin
               sal.push_back(lst[a]);
            end
         end
         for (int i = 0; i < sal.size(); i++) r[N_TABLERO-1-i][c] = celda_t'(sal[i]);
      end
   endfunction

   function automatic matriz_t tablero_azar();
      matriz_t b;
      int      k;
      b = '0;
      for (int f = 0; f < N_TABLERO; f++)
         for (int c = 0; c < N_TABLERO; c++) begin
            k = int'($urandom_range(0, 9));
            if (k < 3)       b[f][c] = '0;
            else if (k < 8)  b[f][c] = celda_t'(2 << (k - 3));
            else if (k == 8) b[f][c] = 12'd1024;
            else             b[f][c] = 12'd2048;
         end
      return b;
   endfunction

   // One full move; matriz_in is scrambled right after acceptance to show it is not re-read.
   task automatic mover(input string tag, input matriz_t b, input matriz_t e, input int pts);
      int lat;
      @(negedge clk);
      bus.matriz_in = b;
      bus.estado    = ESTADO_ABAJO;
      bus.start     = 1'b1;
      @(negedge clk);
      bus.start     = 1'b0;
      bus.matriz_in = tablero_azar();
      chk({tag, " busy"}, 32'(bus.busy), 32'd1);
      lat = 0;
      while (bus.done !== 1'b1 && lat < 12) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, " latency"}, 32'(lat), 32'd5);
      chk_m({tag, " matriz"}, bus.matriz_out, e);
      chk({tag, " puntos"}, 32'(bus.puntos), 32'(pts));
      chk({tag, " movio"}, 32'(bus.movio), 32'(e != b));
      chk({tag, " busy_fin"}, 32'(bus.busy), 32'd0);
      @(negedge clk);
      chk({tag, " done_pulse"}, 32'(bus.done), 32'd0);
   endtask

   initial begin
      matriz_t b, e, cur;
      int      pts, nb, nd;

      n_cmp = 0;
      n_err = 0;
      rst           = 1'b1;
      bus.start     = 1'b0;
      bus.estado    = 4'b0000;
      bus.matriz_in = '0;
      repeat (3) @(negedge clk);
      chk("rst busy",   32'(bus.busy),   32'd0);
      chk("rst done",   32'(bus.done),   32'd0);
      chk("rst movio",  32'(bus.movio),  32'd0);
      chk("rst puntos", 32'(bus.puntos), 32'd0);
      chk_m("rst matriz", bus.matriz_out, '0);
      rst = 1'b0;

      // Four equal tiles in one column merge pairwise.
      b = '0; b[0][0] = 2; b[1][0] = 2; b[2][0] = 2; b[3][0] = 2;
      e = '0; e[2][0] = 4; e[3][0] = 4;
      mover("t1", b, e, 8);

      b = '0; b[0][1] = 2; b[1][1] = 2; b[2][1] = 4;
      b[0][2] = 4; b[2][2] = 4; b[3][2] = 8;
      e = '0; e[2][1] = 4; e[3][1] = 4; e[2][2] = 8; e[3][2] = 8;
      mover("t2", b, e, 12);

      b = '0; b[2][0] = 2; b[3][0] = 4;
      mover("t3", b, b, 0);

      // Two 2048 tiles never merge.
      b = '0; b[2][3] = 12'd2048; b[3][3] = 12'd2048;
      mover("t4", b, b, 0);

      // Wrong direction is ignored and the previous result is held.
      bus.start  = 1'b1;
      bus.estado = ESTADO_ARRIBA;
      bus.matriz_in = tablero_azar();
      nb = 0; nd = 0;
      repeat (8) begin
         @(negedge clk);
         nb += int'(bus.busy);
         nd += int'(bus.done);
      end
      bus.start = 1'b0;
      chk("t4 arriba busy", 32'(nb), 32'd0);
      chk("t4 arriba done", 32'(nd), 32'd0);
      chk_m("t4 arriba held", bus.matriz_out, b);

      // Reset during the second column cycle aborts the move.
      b = '0; b[0][1] = 8; b[3][1] = 8;
      e = '0; e[3][1] = 16;
      mover("t5 pre", b, e, 16);
      @(negedge clk);
      bus.matriz_in = tablero_azar();
      bus.estado    = ESTADO_ABAJO;
      bus.start     = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t5 busy",   32'(bus.busy),   32'd0);
      chk("t5 done",   32'(bus.done),   32'd0);
      chk("t5 puntos", 32'(bus.puntos), 32'd0);
      chk("t5 movio",  32'(bus.movio),  32'd0);
      chk_m("t5 matriz", bus.matriz_out, '0);
      nd = 0;
      repeat (8) begin
         @(negedge clk);
         nd += int'(bus.done);
      end
      chk("t5 no done", 32'(nd), 32'd0);

      // Start held high, board changing mid-move: one done per 6-cycle window.
      @(negedge clk);
      bus.matriz_in = tablero_azar();
      bus.estado    = ESTADO_ABAJO;
      bus.start     = 1'b1;
      for (int w = 0; w < 3; w++) begin
         cur = bus.matriz_in;
         modelo(cur, e, pts);
         nd = 0;
         for (int cyc = 1; cyc <= 6; cyc++) begin
            @(negedge clk);
            if (cyc == 2) bus.matriz_in = tablero_azar();
            nd += int'(bus.done);
         end
         chk("t6 done_at_6", 32'(bus.done), 32'd1);
         chk("t6 done_count", 32'(nd), 32'd1);
         chk_m("t6 matriz", bus.matriz_out, e);
         chk("t6 puntos", 32'(bus.puntos), 32'(pts));
      end
      bus.start = 1'b0;
      repeat (8) @(negedge clk);

      // Random boards against the reference model.
      for (int n = 0; n < 25; n++) begin
         b = tablero_azar();
         modelo(b, e, pts);
         mover("rand", b, e, pts);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
